// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: bounce/chase/fill/blink sweeps with an optional
// trailing all-off/all-on/all-off flash, enabled by LED_SEQ_FLASH_EN.
`timescale 1ns/1ps
module led_pattern_sequencer #(
    parameter int LED_W       = 8,
    parameter int STEP_CYCLES = 50000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [3:0]       repeats,
    input  logic             abort,
    output logic [LED_W-1:0] led,
    output logic             busy,
    output logic             done
);

    localparam int TW = $clog2(STEP_CYCLES + 1);
    localparam int IW = $clog2(2 * LED_W);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
`ifdef LED_SEQ_FLASH_EN
    localparam logic [1:0] S_FLASH = 2'd2;
`endif

    localparam logic [LED_W-1:0] ONES = {LED_W{1'b1}};
    localparam logic [LED_W-1:0] TOP  = {1'b1, {(LED_W-1){1'b0}}};

    logic [1:0]    state_q, state_d;
    logic          start_q;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [3:0]    pass_q, pass_d;
    logic [1:0]    mode_q, mode_d;
    logic [3:0]    reps_q, reps_d;
    logic          done_q, done_d;

    logic          start_edge;
    logic          step_last;
    logic          idx_last;
    logic [IW-1:0] last_idx;
    logic [IW-1:0] pos;

    assign start_edge = start & ~start_q;
    assign step_last  = (tmr_q == TW'(STEP_CYCLES - 1));
    assign idx_last   = (idx_q == last_idx);

    always_comb begin
        last_idx = IW'(1);
        case (mode_q)
            2'b00:   last_idx = IW'(2 * LED_W - 2);
            2'b01:   last_idx = IW'(LED_W - 1);
            2'b10:   last_idx = IW'(LED_W - 1);
            default: last_idx = IW'(1);
        endcase
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        idx_d   = idx_q;
        pass_d  = pass_q;
        mode_d  = mode_q;
        reps_d  = reps_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_edge && !abort) begin
                    state_d = S_SWEEP;
                    tmr_d   = '0;
                    idx_d   = '0;
                    pass_d  = '0;
                    mode_d  = mode;
                    reps_d  = (repeats == 4'd0) ? 4'd1 : repeats;
                end
            end
            S_SWEEP: begin
                if (abort) begin
                    state_d = S_IDLE;
                    tmr_d   = '0;
                    idx_d   = '0;
                    pass_d  = '0;
                end else if (step_last) begin
                    tmr_d = '0;
                    if (idx_last) begin
                        idx_d = '0;
                        if (pass_q == reps_q - 4'd1) begin
                            pass_d = '0;
`ifdef LED_SEQ_FLASH_EN
                            state_d = S_FLASH;
`else
                            state_d = S_IDLE;
                            done_d  = 1'b1;
`endif
                        end else begin
                            pass_d = pass_q + 4'd1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
`ifdef LED_SEQ_FLASH_EN
            S_FLASH: begin
                if (abort) begin
                    state_d = S_IDLE;
                    tmr_d   = '0;
                    idx_d   = '0;
                end else if (step_last) begin
                    tmr_d = '0;
                    if (idx_q == IW'(2)) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                tmr_d   = '0;
                idx_d   = '0;
                pass_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            tmr_q   <= '0;
            idx_q   <= '0;
            pass_q  <= '0;
            mode_q  <= '0;
            reps_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            mode_q  <= mode_d;
            reps_q  <= reps_d;
            done_q  <= done_d;
        end
    end

    // Bounce walks down then folds back: index k maps to LED position
    // k on the way down and 2*LED_W-2-k on the way back.
    always_comb begin
        led = '0;
        pos = '0;
        case (state_q)
            S_SWEEP: begin
                case (mode_q)
                    2'b00: begin
                        pos = (idx_q < IW'(LED_W)) ? idx_q
                            : IW'(2 * LED_W - 2) - idx_q;
                        led = TOP >> pos;
                    end
                    2'b01:   led = TOP >> idx_q;
                    2'b10:   led = ~(ONES >> (idx_q + 1'b1));
                    default: led = (idx_q == '0) ? ONES : '0;
                endcase
            end
`ifdef LED_SEQ_FLASH_EN
            S_FLASH: led = (idx_q == IW'(1)) ? ONES : '0;
`endif
            default: led = '0;
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: queue-based per-cycle reference model,
// directed scenarios with literal pins, then randomized traffic.
`timescale 1ns/1ps
module tb_led_pattern_sequencer;

    localparam int W = 4;
    localparam int S = 3;
`ifdef LED_SEQ_FLASH_EN
    localparam int FL = 3;
`else
    localparam int FL = 0;
`endif

    logic         clk;
    logic         reset;
    logic         start;
    logic [1:0]   mode;
    logic [3:0]   repeats;
    logic         abort;
    logic [W-1:0] led;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_bad = 0;

    led_pattern_sequencer #(.LED_W(W), .STEP_CYCLES(S)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mode    (mode),
        .repeats (repeats),
        .abort   (abort),
        .led     (led),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    function automatic int nsteps(input logic [1:0] m);
        case (m)
            2'b00:   return 2 * W - 1;
            2'b01:   return W;
            2'b10:   return W;
            default: return 2;
        endcase
    endfunction

    function automatic logic [W-1:0] pat(input logic [1:0] m, input int k);
        logic [W-1:0] v;
        int p;
        v = '0;
        case (m)
            2'b00: begin
                p = (k < W) ? k : 2 * W - 2 - k;
                v[W-1-p] = 1'b1;
            end
            2'b01: v[W-1-k] = 1'b1;
            2'b10: for (int j = 0; j <= k; j++) v[W-1-j] = 1'b1;
            default: v = (k == 0) ? '1 : '0;
        endcase
        return v;
    endfunction

    // Reference model: the whole run is expanded into one LED value per
    // cycle at the start edge; the front of the queue is what must show.
    logic [W-1:0] q[$];
    bit           prev_s;
    bit           m_done;

    task automatic build(input logic [1:0] m, input logic [3:0] r);
        int rr;
        rr = (r == 0) ? 1 : int'(r);
        for (int p = 0; p < rr; p++)
            for (int k = 0; k < nsteps(m); k++)
                for (int c = 0; c < S; c++) q.push_back(pat(m, k));
        for (int k = 0; k < FL; k++)
            for (int c = 0; c < S; c++) q.push_back((k == 1) ? '1 : '0);
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            prev_s = 1'b0;
            m_done = 1'b0;
        end else begin
            bit e;
            e = start && !prev_s;
            prev_s = start;
            m_done = 1'b0;
            if (q.size() != 0) begin
                if (abort) q.delete();
                else begin
                    void'(q.pop_front());
                    if (q.size() == 0) m_done = 1'b1;
                end
            end else if (e && !abort) begin
                build(mode, repeats);
            end
        end
    end

    always @(negedge clk) begin
        logic [W-1:0] el;
        el = (q.size() != 0) ? q[0] : '0;
        chk("cycle{led,busy,done}", {26'd0, led, busy, done},
            {26'd0, el, q.size() != 0, m_done});
    end

    task automatic run(input logic [1:0] m, input logic [3:0] r,
                       input int exp_cyc, input logic [W-1:0] first,
                       input bit poke, input string nm);
        int n;
        bit got;
        logic [W-1:0] fl;
        n = 0;
        got = 0;
        fl = '0;
        @(posedge clk); #1;
        mode = m;
        repeats = r;
        start = 1'b1;
        while (!got && n < 2000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) begin
                fl = led;
                start = 1'b0;
            end
            if (poke && n == 4) begin
                start = 1'b1;
                mode = 2'b00;
                repeats = 4'd9;
            end
            if (poke && n == 6) start = 1'b0;
            if (done) got = 1;
        end
        chk({nm, "_first"}, {28'd0, fl}, {28'd0, first});
        chk({nm, "_len"}, got ? n - 1 : -1, exp_cyc);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        bit sawd;
        reset = 1'b1;
        start = 1'b0;
        mode = '0;
        repeats = '0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out", {26'd0, led, busy, done}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);

        run(2'b00, 4'd2, (14 + FL) * S, 4'b1000, 0, "bounce");
        run(2'b10, 4'd0, (4 + FL) * S, 4'b1000, 0, "fill");
        run(2'b11, 4'd1, (2 + FL) * S, 4'b1111, 1, "blink_poke");
        run(2'b01, 4'd3, (12 + FL) * S, 4'b1000, 0, "chase");

        // abort at the second step
        @(posedge clk); #1;
        mode = 2'b01;
        repeats = 4'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort_step2", {28'd0, led}, 32'b0100);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_idle", {26'd0, led, busy, done}, 32'd0);
        sawd = 0;
        repeat (20) begin
            @(negedge clk);
            sawd |= done;
        end
        chk("abort_nodone", {31'd0, sawd}, 32'd0);

        // abort and start edge together in idle
        @(posedge clk); #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_wins", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;

        // reset mid-run with start held high
        @(posedge clk); #1;
        mode = 2'b10;
        repeats = 4'd1;
        start = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("reset_midrun", {26'd0, led, busy, done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("restart_after_reset", {27'd0, led, busy}, {27'd0, 4'b1000, 1'b1});
        start = 1'b0;
        wait_idle("reset_run_drain");

        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 5) == 0) start = ~start;
            mode = 2'($urandom);
            repeats = 4'($urandom_range(0, 3));
            abort = ($urandom_range(0, 60) == 0);
        end
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        wait_idle("random_drain");
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
